// File: rtl/multi_gate_pipe.sv
// rtl/multi_gate_pipe.sv - two-stage pipelined multi-operand bitwise gate with handshakes
module multi_gate_pipe #(
   parameter int WIDTH   = 8,
   parameter int NUM_IN  = 2,
   parameter int COUNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [2:0]              in_op,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_y,
   output logic [2:0]              out_op,
   output logic [COUNT_W-1:0]      op_count,
   output logic                    err
);

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_NOR  = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_NOT  = 3'b110;
   localparam logic [2:0] OP_ILL  = 3'b111;

   logic                    s1_valid;
   logic [NUM_IN*WIDTH-1:0] s1_data;
   logic [2:0]              s1_op;
   logic                    s2_adv;
   logic                    s1_adv;
   logic                    in_fire;
   logic                    out_fire;
   logic [WIDTH-1:0]        red_and;
   logic [WIDTH-1:0]        red_or;
   logic [WIDTH-1:0]        red_xor;
   logic [WIDTH-1:0]        result;

   // Pipeline flow control: a stage moves when it is empty or its consumer takes its beat.
   always_comb begin
      out_fire = out_valid & out_ready;
      s2_adv   = ~out_valid | out_ready;
      s1_adv   = ~s1_valid | s2_adv;
      in_ready = s1_adv & rst_n;
      in_fire  = in_valid & in_ready;
   end

   // Reduce all registered operands and pick the result for the registered op.
   always_comb begin
      red_and = '1;
      red_or  = '0;
      red_xor = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         red_and = red_and & s1_data[k*WIDTH +: WIDTH];
         red_or  = red_or  | s1_data[k*WIDTH +: WIDTH];
         red_xor = red_xor ^ s1_data[k*WIDTH +: WIDTH];
      end
      case (s1_op)
         OP_AND:  result = red_and;
         OP_OR:   result = red_or;
         OP_NAND: result = ~red_and;
         OP_NOR:  result = ~red_or;
         OP_XOR:  result = red_xor;
         OP_XNOR: result = ~red_xor;
         OP_NOT:  result = ~s1_data[WIDTH-1:0];
         default: result = '0;
      endcase
   end

   // Stage 1: capture operands and op on an input handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_op    <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= in_data;
            s1_op   <= in_op;
         end
      end
   end

   // Stage 2: register the computed result; held while the output is stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_y     <= '0;
         out_op    <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_y  <= result;
            out_op <= s1_op;
         end
      end
   end

   // Completed-output counter, saturating at all ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (out_fire && (op_count != {COUNT_W{1'b1}})) begin
         op_count <= op_count + COUNT_W'(1);
      end
   end

   // Sticky flag for any accepted illegal op.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (in_fire && (in_op == OP_ILL)) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multi_gate_pipe.sv
// tb/tb_multi_gate_pipe.sv - scoreboard bench for multi_gate_pipe
module tb_multi_gate_pipe;

   localparam int WIDTH   = 8;
   localparam int NUM_IN  = 4;
   localparam int COUNT_W = 4;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    in_valid;
   logic                    in_ready;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [2:0]              in_op;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_y;
   logic [2:0]              out_op;
   logic [COUNT_W-1:0]      op_count;
   logic                    err;

   typedef struct {
      logic [7:0] y;
      logic [2:0] op;
      int         cyc;
      bit         lat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   lat_mode = 1'b0;

   multi_gate_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .COUNT_W(COUNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_op(out_op), .op_count(op_count), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [31:0] d, input logic [2:0] op);
      logic [7:0] a, b, c, e;
      a = d[7:0]; b = d[15:8]; c = d[23:16]; e = d[31:24];
      case (op)
         3'd0:    return a & b & c & e;
         3'd1:    return a | b | c | e;
         3'd2:    return ~(a & b & c & e);
         3'd3:    return ~(a | b | c | e);
         3'd4:    return a ^ b ^ c ^ e;
         3'd5:    return ~(a ^ b ^ c ^ e);
         3'd6:    return ~a;
         default: return 8'h00;
      endcase
   endfunction

   // Output monitor: pop the oldest expectation on every output handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("spurious_out", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("out_y", out_y, mon_e.y);
            check("out_op", out_op, mon_e.op);
            if (mon_e.lat) check("latency", cyc - mon_e.cyc, 2);
         end
      end
   end

   task automatic send(input logic [31:0] d, input logic [2:0] op, input logic [7:0] ey, input int budget);
      exp_t e;
      bit   done = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_op    = op;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e.y = ey; e.op = op; e.cyc = cyc; e.lat = lat_mode;
            sb.push_back(e);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_data  = $urandom;
      in_op    = 3'b111;
      if (!done) check("send_timeout", 0, 1);
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk); #1;
         if (sb.size() == 0 && !out_valid) ok = 1'b1;
      end
      check("drain", ok, 1);
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [2:0]  op;
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hDEAD_BEEF;
      in_op     = 3'b111;
      out_ready = 1'b1;

      // reset state, in_valid ignored while in reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_op_count", op_count, 0);
      check("rst_err", err, 0);
      @(posedge clk); #1;

      // scenario 1: handshake in first cycle out of reset, back-to-back NOR
      rst_n    = 1'b1;
      lat_mode = 1'b1;
      send({8'h00, 8'h00, 8'hF0, 8'h0F}, 3'b011, 8'h00, 1);
      send(32'h0, 3'b011, 8'hFF, 1);
      drain();

      // scenario 2: four-operand reductions
      send({8'h08, 8'h04, 8'h02, 8'h01}, 3'b011, 8'hF0, 1);
      send({8'h08, 8'h04, 8'h02, 8'h01}, 3'b100, 8'h0F, 1);
      send({8'h7F, 8'hFF, 8'hFF, 8'hFF}, 3'b010, 8'h80, 1);
      drain();

      // scenario 3: backpressure with three beats offered
      pulse_reset();
      lat_mode  = 1'b0;
      out_ready = 1'b0;
      send(32'hFFFF_FFFF, 3'b000, 8'hFF, 1);
      send({8'h00, 8'h00, 8'h02, 8'h01}, 3'b001, 8'h03, 1);
      in_valid = 1'b1;
      in_data  = 32'h0000_005A;
      in_op    = 3'b110;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 0);
         check("stall_out_valid", out_valid, 1);
         check("stall_out_y", out_y, 8'hFF);
         check("stall_out_op", out_op, 3'b000);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send(32'h0000_005A, 3'b110, 8'hA5, 1);
      drain();
      check("s3_op_count", op_count, 3);

      // scenario 4: illegal op sets sticky err
      lat_mode = 1'b1;
      check("s4_err_before", err, 0);
      send(32'h1234_5678, 3'b111, 8'h00, 1);
      check("s4_err_set", err, 1);
      send({8'h00, 8'h00, 8'h0F, 8'h0F}, 3'b101, 8'hFF, 1);
      drain();
      check("s4_err_sticky", err, 1);

      // scenario 5: counter saturation with sustained random traffic
      pulse_reset();
      for (int i = 0; i < 14; i++) begin
         d  = $urandom;
         op = 3'($urandom_range(0, 6));
         send(d, op, model(d, op), 1);
      end
      drain();
      check("s5_count14", op_count, 14);
      for (int i = 0; i < 6; i++) begin
         d  = $urandom;
         op = 3'($urandom_range(0, 6));
         send(d, op, model(d, op), 1);
      end
      drain();
      check("s5_count_sat", op_count, 4'hF);

      // scenario 6: reset with two beats in flight
      send(32'h0000_00FF, 3'b001, 8'hFF, 1);
      send(32'h0000_0000, 3'b111, 8'h00, 1);
      rst_n     = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      sb.delete();
      @(negedge clk);
      check("s6_out_valid", out_valid, 0);
      check("s6_op_count", op_count, 0);
      check("s6_err", err, 0);
      @(posedge clk); #1;
      send({8'h01, 8'h01, 8'h01, 8'h01}, 3'b000, 8'h01, 1);
      drain();
      check("s6_op_count_after", op_count, 1);

      check("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_gate_pipe.md
MULTI_GATE_PIPE -- requirements
Module: multi_gate_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each operand and of the result (legal 1..64).
REQ-002 SHALL have parameter NUM_IN, default 2: number of operands (legal 2..8).
REQ-003 SHALL have parameter COUNT_W, default 16: width of the completed-operation counter (legal 2..32).
REQ-004 SHALL have port clk  input  1  rising-edge clock; the block uses one clock.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  upstream beat valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port in_data  input  NUM_IN*WIDTH  operands; operand k occupies bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port in_op  input  3  operation select, sampled with in_data.
REQ-010 SHALL have port out_valid  output  1  result beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_y  output  WIDTH  result.
REQ-013 SHALL have port out_op  output  3  op code that produced out_y.
REQ-014 SHALL have port op_count  output  COUNT_W  number of completed output handshakes.
REQ-015 SHALL have port err  output  1  sticky illegal-op flag.

Function
REQ-016 SHALL perform a bitwise reduction over all NUM_IN operands per in_op: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT of operand 0 only.
REQ-017 SHALL treat in_op=111 as illegal: the result is all zeros, out_op=111 passes through, and err is set.
REQ-018 SHALL accept an input beat only on a cycle where in_valid=1 and in_ready=1 (input handshake).
REQ-019 SHALL complete an output beat only on a cycle where out_valid=1 and out_ready=1 (output handshake).
REQ-020 SHALL use a two-stage pipeline: stage 1 registers operands and op, and stage 2 registers the computed result and op.
REQ-021 SHALL present a result with out_valid=1 exactly 2 cycles after its input handshake when there is no backpressure.
REQ-022 SHALL sustain one beat per cycle when out_ready is held at 1.
REQ-023 SHALL advance stage 2 when it is empty or an output handshake occurs, and SHALL advance stage 1 when it is empty or stage 2 advances.
REQ-024 SHALL drive in_ready combinationally as (stage 1 empty OR stage 1 advancing) AND rst_n=1.
REQ-025 SHALL hold out_y and out_op stable while out_valid=1 and out_ready=0.
REQ-026 SHALL deliver results in input order, with no drops and no duplicates; at most 2 beats are in flight.
REQ-027 SHALL ignore in_data and in_op when no input handshake occurs.
REQ-028 SHALL increment op_count by 1 on each output handshake and SHALL saturate it at 2^COUNT_W-1 (no wrap).
REQ-029 SHALL set err in the cycle after an input handshake with in_op=111, and err SHALL remain 1 until reset.
REQ-030 SHALL, on simultaneous input and output handshakes with both stages full, accept the new beat with no bubble.

Reset
REQ-031 SHALL, on a rising clk edge with rst_n=0, clear both stage valid bits, out_y, out_op, op_count and err to 0.
REQ-032 SHALL discard in-flight beats on reset mid-operation, with no output handshake for them and no count for them.
REQ-033 SHALL hold in_ready=0 while rst_n=0 and ignore in_valid during that time.
REQ-034 SHALL allow an input handshake in the first cycle with rst_n=1.

Verification
REQ-035 Scenario 1 (WIDTH=8, NUM_IN=2, out_ready=1): NOR of 8'h0F and 8'hF0 -> out_y=8'h00, 2 cycles after handshake; next beat NOR of 8'h00 and 8'h00 -> 8'hFF in the following cycle.
REQ-036 Scenario 2 (NUM_IN=4): NOR of 01, 02, 04, 08 -> 8'hF0; XOR of the same operands -> 8'h0F; NAND of FF, FF, FF, 7F -> 8'h80.
REQ-037 Scenario 3: out_ready=0 with 3 beats offered -> 2 beats accepted and in_ready=0 on the third; raise out_ready -> all 3 results arrive in order, out_y stable while stalled, op_count=3.
REQ-038 Scenario 4: in_op=111 -> out_y=8'h00, out_op=3'b111, err=1; then a legal op -> correct result, err remains 1.
REQ-039 Scenario 5 (COUNT_W=4): 20 output handshakes -> op_count=4'hF.
REQ-040 Scenario 6: rst_n=0 for one cycle with 2 beats in flight -> out_valid=0, op_count=0, err=0 the next cycle; a new beat then completes with latency 2.
